// File: rtl/gauss_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gauss_pkg
// Description : Shared defaults and FSM encoding for the Gaussian 3x3 window
//               generator and the convolution top that consumes it.
// Revision    : 1.0 - initial release
// ============================================================================
package gauss_pkg;

  localparam int unsigned c_img_w_def = 32;
  localparam int unsigned c_img_h_def = 32;
  localparam int unsigned c_pix_w_def = 8;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } gauss_state_e;

  // Counter width able to index 0..n-1, never narrower than one bit
  function automatic int unsigned gauss_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gauss_line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gauss_line_fifo
// Description : Fixed-length delay line of DEPTH pixels; advances one slot on
//               every shift enable. Output is the pixel pushed DEPTH shifts
//               earlier. Storage is intentionally left unreset.
// Revision    : 1.0 - initial release
// ============================================================================
module gauss_line_fifo
  import gauss_pkg::*;
#(
  parameter int DEPTH = c_img_w_def,
  parameter int WIDTH = c_pix_w_def
) (
  input  logic             clk,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Shift the whole line by one pixel when enabled
  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/gauss_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : gauss_window_gen
// Description : Streams a raster image and emits one zero-padded 3x3
//               neighbourhood per pixel, in raster order of the centre.
//               Two line delays supply the rows above; a trailing flush of
//               IMG_W+1 zero pixels drains the last row.
// Revision    : 1.0 - initial release
// ============================================================================
module gauss_window_gen
  import gauss_pkg::*;
#(
  parameter int IMG_W = c_img_w_def,
  parameter int IMG_H = c_img_h_def,
  parameter int PIX_W = c_pix_w_def
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   in_pix,
  output logic               in_ready,
  output logic               win_valid,
  output logic [9*PIX_W-1:0] win_data,
  input  logic               win_ready,
  output logic               frame_done
);

  localparam int unsigned c_npix  = IMG_W * IMG_H;
  localparam int unsigned c_pend  = c_npix + IMG_W + 1;   // one past last flush slot
  localparam int unsigned c_p_w   = $clog2(c_pend + 1);
  localparam int unsigned c_col_w = gauss_cnt_w(IMG_W);
  localparam int unsigned c_row_w = gauss_cnt_w(IMG_H);

  localparam logic [c_p_w-1:0]   c_p_run_last = c_p_w'(c_npix - 1);
  localparam logic [c_p_w-1:0]   c_p_first    = c_p_w'(IMG_W + 1);
  localparam logic [c_p_w-1:0]   c_p_end      = c_p_w'(c_pend);
  localparam logic [c_col_w-1:0] c_col_last   = c_col_w'(IMG_W - 1);
  localparam logic [c_row_w-1:0] c_row_last   = c_row_w'(IMG_H - 1);

  gauss_state_e        state_q, state_d;
  logic [c_p_w-1:0]    p_q, p_d;
  logic [c_col_w-1:0]  col_q, col_d;      // column of the next window centre
  logic [c_row_w-1:0]  row_q, row_d;      // row of the next window centre
  logic [PIX_W-1:0]    win_q [3][3];      // [row top..bottom][col left..right]
  logic                out_valid_q;
  logic [9*PIX_W-1:0]  out_data_q;

  logic                w_adv_ok;
  logic                w_adv;
  logic                w_load;
  logic [PIX_W-1:0]    w_new_pix;
  logic [PIX_W-1:0]    w_line0;
  logic [PIX_W-1:0]    w_line1;
  logic [PIX_W-1:0]    w_col [3];
  logic [9*PIX_W-1:0]  w_win_d;

  // The pipeline may move when the output slot is empty or being drained
  assign w_adv_ok  = !out_valid_q || win_ready;
  assign w_adv     = ((state_q == ST_RUN) && in_valid && w_adv_ok) ||
                     ((state_q == ST_FLUSH) && (p_q < c_p_end) && w_adv_ok);
  assign w_load    = w_adv && (p_q >= c_p_first);
  assign w_new_pix = (state_q == ST_RUN) ? in_pix : '0;

  gauss_line_fifo #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_line0 (
    .clk        (clk),
    .shift_en_i (w_adv),
    .din_i      (w_new_pix),
    .dout_o     (w_line0)
  );

  gauss_line_fifo #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_line1 (
    .clk        (clk),
    .shift_en_i (w_adv),
    .din_i      (w_line0),
    .dout_o     (w_line1)
  );

  // Incoming column: two rows up, one row up, current pixel
  always_comb begin
    w_col[0] = w_line1;
    w_col[1] = w_line0;
    w_col[2] = w_new_pix;
  end

  // Window register array slides one column left on each advance
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
        win_q[r][2] <= w_col[r];
      end
    end
  end

  // Post-shift window with out-of-image neighbours forced to zero
  always_comb begin
    w_win_d = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        logic [PIX_W-1:0] tap;
        logic             masked;
        tap    = (c == 0) ? win_q[r][1] : ((c == 1) ? win_q[r][2] : w_col[r]);
        masked = ((r == 0) && (row_q == '0))        ||
                 ((r == 2) && (row_q == c_row_last)) ||
                 ((c == 0) && (col_q == '0))        ||
                 ((c == 2) && (col_q == c_col_last));
        if (!masked) begin
          w_win_d[PIX_W*(r*3+c) +: PIX_W] = tap;
        end
      end
    end
  end

  // Next-state, position and centre-coordinate logic
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          p_d     = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_RUN: begin
        if (w_adv) begin
          p_d = p_q + 1'b1;
          if (p_q == c_p_run_last) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (w_adv) begin
          p_d = p_q + 1'b1;
        end
        if ((p_q == c_p_end) && out_valid_q && win_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (w_load) begin
      if (col_q == c_col_last) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Output slot: drains on acceptance, refills on every window load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (out_valid_q && win_ready) begin
        out_valid_q <= 1'b0;
      end
      if (w_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= w_win_d;
      end
    end
  end

  assign in_ready   = (state_q == ST_RUN) && w_adv_ok;
  assign win_valid  = out_valid_q;
  assign win_data   = out_data_q;
  assign frame_done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_gauss_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_gauss_window_gen
// Description : Self-checking bench for gauss_window_gen. A frame-level model
//               builds every expected window from the image itself; a monitor
//               checks each accepted window, stall stability and frame_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gauss_window_gen;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int PW   = 8;
  localparam int NPIX = W * H;

  // Hand-computed windows (slot 0 in the low byte)
  localparam logic [71:0] c_lit_ramp_00 =
    {8'h21, 8'h20, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [71:0] c_lit_ramp_3131 =
    {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'h00, 8'hDF, 8'hDE};
  localparam logic [71:0] c_lit_const_00 =
    {8'h80, 8'h80, 8'h00, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          in_valid;
  logic [PW-1:0] in_pix;
  logic          in_ready;
  logic          win_valid;
  logic [71:0]   win_data;
  logic          win_ready = 1'b1;
  logic          frame_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [71:0] exp_arr [$];
  logic [71:0] got_arr [$];
  int          got_total = 0;
  int          skew      = 0;
  int          fd_total  = 0;
  bit          bp        = 1'b0;

  gauss_window_gen #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_pix     (in_pix),
    .in_ready   (in_ready),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pix(input int kind, input int r, input int c);
    if (kind == 0) return PW'((r * 32 + c) & 8'hFF);
    return 8'h80;
  endfunction

  // Zero-padded neighbourhood of (r,c) straight from the image definition
  function automatic logic [71:0] model_win(input int kind, input int r, input int c);
    logic [71:0] res;
    res = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr;
        int cc;
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
          res[8*((dr+1)*3 + (dc+1)) +: 8] = pix(kind, rr, cc);
        end
      end
    end
    return res;
  endfunction

  task automatic push_frame(input int kind);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        exp_arr.push_back(model_win(kind, r, c));
      end
    end
  endtask

  // Downstream readiness: always ready, or a coin flip per cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      win_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: accepted windows, stall stability, frame_done width
  initial begin
    logic        stall_prev;
    logic [71:0] data_prev;
    logic        fd_prev;
    stall_prev = 1'b0;
    data_prev  = '0;
    fd_prev    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_prev) begin
          chk("stall_valid", 72'(win_valid), 72'd1);
          chk("stall_data", win_data, data_prev);
        end
        if (win_valid && !win_ready) begin
          chk("stall_in_ready", 72'(in_ready), 72'd0);
        end
        if (win_valid && win_ready) begin
          int idx;
          idx = got_total + skew;
          if (idx < exp_arr.size()) begin
            chk("window", win_data, exp_arr[idx]);
          end else begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_window: got %h expected none", win_data);
          end
          got_arr.push_back(win_data);
          got_total++;
        end
        if (frame_done) begin
          fd_total++;
          if (fd_prev) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_width: got 2+ cycles expected 1");
          end
        end
      end
      stall_prev = rst_n && win_valid && !win_ready;
      data_prev  = win_data;
      fd_prev    = rst_n && frame_done;
    end
  end

  // Pulse en in IDLE and confirm input opens on the following cycle
  task automatic start_frame(input int kind);
    push_frame(kind);
    en = 1'b1;
    tick();
    en = 1'b0;
    @(negedge clk);
    chk("in_ready_after_en", 72'(in_ready), 72'd1);
    tick();
  endtask

  task automatic drive_pixels(input int kind, input bit gap, input int limit);
    int i;
    int cyc;
    i   = 0;
    cyc = 0;
    while (i < limit && cyc < 20000) begin
      in_valid = gap ? (cyc % 4 == 0) : 1'b1;
      in_pix   = pix(kind, i / W, i % W);
      @(negedge clk);
      if (in_valid && in_ready) i++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (i < limit) begin
      n_checks++;
      n_fail++;
      $display("FAIL pixel_timeout: got %0d pixels expected %0d", i, limit);
    end
  endtask

  task automatic run_frame(input int kind, input bit gap, input bit bpv, output int base);
    int fd0;
    int n;
    base = got_total;
    fd0  = fd_total;
    bp   = bpv;
    start_frame(kind);
    drive_pixels(kind, gap, NPIX);
    n = 0;
    while (fd_total == fd0 && n < 10000) begin
      tick();
      n++;
    end
    bp = 1'b0;
    chk("frame_done_count", 72'(fd_total - fd0), 72'd1);
    chk("window_count", 72'(got_total - base), 72'(NPIX));
  endtask

  initial begin
    int base;
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_pix   = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_in_ready", 72'(in_ready), 72'd0);
    chk("rst_win_valid", 72'(win_valid), 72'd0);
    chk("rst_win_data", win_data, 72'd0);
    chk("rst_frame_done", 72'(frame_done), 72'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Pin the model against hand-derived windows
    chk("model_ramp_00", model_win(0, 0, 0), c_lit_ramp_00);
    chk("model_ramp_3131", model_win(0, 31, 31), c_lit_ramp_3131);
    chk("model_const_00", model_win(1, 0, 0), c_lit_const_00);

    // Ramp, full throughput
    run_frame(0, 1'b0, 1'b0, base);
    if (got_arr.size() >= base + NPIX) begin
      chk("ramp_first", got_arr[base], c_lit_ramp_00);
      chk("ramp_last", got_arr[base + NPIX - 1], c_lit_ramp_3131);
    end

    // Ramp with random backpressure
    run_frame(0, 1'b0, 1'b1, base);

    // Ramp with input gaps
    run_frame(0, 1'b1, 1'b0, base);

    // Abort after 500 pixels
    start_frame(0);
    drive_pixels(0, 1'b0, 500);
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("midrst_in_ready", 72'(in_ready), 72'd0);
    chk("midrst_win_valid", 72'(win_valid), 72'd0);
    chk("midrst_win_data", win_data, 72'd0);
    chk("midrst_frame_done", 72'(frame_done), 72'd0);
    tick();
    rst_n = 1'b1;
    skew  = exp_arr.size() - got_total;
    tick();
    run_frame(0, 1'b0, 1'b0, base);
    if (got_arr.size() > base) chk("midrst_first", got_arr[base], c_lit_ramp_00);

    // Back-to-back: en in the IDLE cycle right after DONE
    run_frame(0, 1'b0, 1'b0, base);
    run_frame(1, 1'b0, 1'b0, base);
    if (got_arr.size() > base) chk("b2b_const_first", got_arr[base], c_lit_const_00);

    for (int k = 0; k < 5; k++) tick();
    chk("no_stray_windows", 72'(got_total + skew), 72'(exp_arr.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
